wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_fifo.sv | 136 +++++++++++++
 rtl/wb_arbiter.sv | 115 +++++++++++
 tb/tb_wb_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared defaults and FIFO occupancy state for the register-file writeback arbiter.
package wb_pkg;

  // Default register write data width.
  localparam int DATA_W_DEF = 16;
  // Default register address width (8 architectural registers).
  localparam int REG_AW_DEF = 3;
  // Default depth of the ALU holding FIFO.
  localparam int DEPTH_DEF  = 2;

  // Occupancy of the ALU holding FIFO.
  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    BUFFERED = 2'd1,
    FULL     = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/wb_fifo.sv
// ALU holding FIFO: entry storage, wrap-around pointers, occupancy count and
// FSM, plus a per-register "pending" map built from the valid entries only.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int NREG  = 2 ** REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [REG_AW-1:0] push_reg,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [REG_AW-1:0] head_reg,
  output logic [DATA_W-1:0] head_data,
  output logic              empty,
  output logic              full,
  output logic [CW-1:0]     count,
  output logic [NREG-1:0]   pending
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  // Entry storage; contents are only meaningful below the current count.
  logic [REG_AW-1:0] ent_reg_q  [DEPTH];
  logic [DATA_W-1:0] ent_data_q [DEPTH];

  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  fifo_state_e       state_q, state_d;
  logic              do_push, do_pop;

  logic [DEPTH-1:0]      entry_valid;
  logic [NREG*DEPTH-1:0] hit_flat;

  // Qualify requests: never pop when empty, never push when full unless a pop frees a slot.
  always_comb begin
    do_pop  = pop && (state_q != EMPTY);
    do_push = push && ((state_q != FULL) || do_pop);
  end

  // Next pointers and count; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + ONE_C;
    end else if (do_pop && !do_push) begin
      count_d = count_q - ONE_C;
    end
  end

  // Occupancy FSM: moves only on an unbalanced push or pop at the boundary counts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (do_push && !do_pop) begin
          state_d = BUFFERED;
        end
      end
      BUFFERED: begin
        if (do_push && !do_pop && (count_q == DEPTH_C - ONE_C)) begin
          state_d = FULL;
        end else if (do_pop && !do_push && (count_q == ONE_C)) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (do_pop && !do_push) begin
          state_d = BUFFERED;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Control registers; reset empties the FIFO so stale entries can never issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= EMPTY;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
    end
  end

  // Entry storage write on an accepted push; no reset needed since validity comes from count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      ent_reg_q[wr_ptr_q]  <= push_reg;
      ent_data_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_reg  = ent_reg_q[rd_ptr_q];
  assign head_data = ent_data_q[rd_ptr_q];
  assign empty     = (state_q == EMPTY);
  assign full      = (state_q == FULL);
  assign count     = count_q;

  // An entry is live when its distance from the read pointer is below the count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    logic [PW-1:0] offset;
    assign offset          = PW'(gi) - rd_ptr_q;
    assign entry_valid[gi] = (CW'(offset) < count_q);
  end

  // Register r is pending while any live entry targets it.
  for (genvar gj = 0; gj < NREG; gj++) begin : g_pend
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign hit_flat[gj*DEPTH + gi] = entry_valid[gi] && (ent_reg_q[gi] == REG_AW'(gj));
    end
    assign pending[gj] = |hit_flat[gj*DEPTH +: DEPTH];
  end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: loads win, buffered ALU results drain next,
// and an ALU result bypasses the FIFO only when nothing else is waiting, so
// ALU writes always retire in issue order. The chosen write is registered.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int NREG  = 2 ** REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [NREG-1:0]   pending,
  output logic [CW-1:0]     fifo_count
);

  logic              fifo_push, fifo_pop;
  logic              fifo_empty, fifo_full;
  logic [REG_AW-1:0] head_reg;
  logic [DATA_W-1:0] head_data;

  logic              alu_accept, bypass, grant;
  logic [REG_AW-1:0] grant_reg;
  logic [DATA_W-1:0] grant_data;

  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  wb_fifo #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_reg  (alu_reg),
    .push_data (alu_data),
    .pop       (fifo_pop),
    .head_reg  (head_reg),
    .head_data (head_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count),
    .pending   (pending)
  );

  // Arbitration: load first, then FIFO head, then ALU bypass; accepted ALU work that loses is buffered.
  always_comb begin
    fifo_pop   = !fifo_empty && !mem_valid;
    alu_ready  = rst && (!fifo_full || fifo_pop);
    alu_accept = alu_valid && alu_ready;
    bypass     = alu_accept && !mem_valid && fifo_empty;
    fifo_push  = alu_accept && !bypass;

    grant      = 1'b0;
    grant_reg  = '0;
    grant_data = '0;
    if (mem_valid) begin
      grant      = 1'b1;
      grant_reg  = mem_reg;
      grant_data = mem_data;
    end else if (fifo_pop) begin
      grant      = 1'b1;
      grant_reg  = head_reg;
      grant_data = head_data;
    end else if (bypass) begin
      grant      = 1'b1;
      grant_reg  = alu_reg;
      grant_data = alu_data;
    end
  end

  // Next write port value: register 0 grants are consumed silently, address/data hold unless a real write issues.
  always_comb begin
    rf_we_d    = grant && (grant_reg != '0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (rf_we_d) begin
      rf_waddr_d = grant_reg;
      rf_wdata_d = grant_data;
    end
  end

  // Write port register, one cycle behind the grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations, plus a
// queue-based model compared against the DUT on every falling edge.
module tb_wb_arbiter;

  localparam int DATA_W = 16;
  localparam int REG_AW = 3;
  localparam int DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic        alu_ready;
  logic [2:0]  alu_reg;
  logic [15:0] alu_data;
  logic        mem_valid;
  logic [2:0]  mem_reg;
  logic [15:0] mem_data;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [7:0]  pending;
  logic [1:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  r;
    logic [15:0] d;
  } ent_t;

  ent_t        mq[$];
  logic        m_we;
  logic [2:0]  m_waddr;
  logic [15:0] m_wdata;

  always #5 clk = ~clk;

  wb_arbiter #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_reg    (alu_reg),
    .alu_data   (alu_data),
    .mem_valid  (mem_valid),
    .mem_reg    (mem_reg),
    .mem_data   (mem_data),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .pending    (pending),
    .fifo_count (fifo_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic mv, input logic [2:0] mr, input logic [15:0] md,
                        input logic av, input logic [2:0] ar, input logic [15:0] ad);
    mem_valid = mv;
    mem_reg   = mr;
    mem_data  = md;
    alu_valid = av;
    alu_reg   = ar;
    alu_data  = ad;
  endtask

  task automatic idle();
    set_in(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [2:0] a, input logic [15:0] d);
    chk({tag, "_we"}, 32'(rf_we), 32'(we));
    chk({tag, "_waddr"}, 32'(rf_waddr), 32'(a));
    chk({tag, "_wdata"}, 32'(rf_wdata), 32'(d));
  endtask

  // Model: FIFO as a queue, one grant per cycle by priority; compared every falling edge.
  initial begin : model_cmp
    logic        e_ready;
    logic [7:0]  e_pend;
    logic        g;
    logic        acc;
    logic [2:0]  gr;
    logic [15:0] gd;
    ent_t        e;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        mq.delete();
        m_we    = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
      end
      e_ready = rst && ((mq.size() < DEPTH) || (mq.size() != 0 && !mem_valid));
      e_pend  = '0;
      foreach (mq[i]) e_pend[mq[i].r] = 1'b1;
      chk("m_alu_ready", 32'(alu_ready), 32'(e_ready));
      chk("m_fifo_count", 32'(fifo_count), 32'(mq.size()));
      chk("m_pending", 32'(pending), 32'(e_pend));
      chk("m_rf_we", 32'(rf_we), 32'(m_we));
      chk("m_rf_waddr", 32'(rf_waddr), 32'(m_waddr));
      chk("m_rf_wdata", 32'(rf_wdata), 32'(m_wdata));
      if (rst) begin
        g   = 1'b0;
        gr  = '0;
        gd  = '0;
        acc = alu_valid && e_ready;
        if (mem_valid) begin
          g  = 1'b1;
          gr = mem_reg;
          gd = mem_data;
        end else if (mq.size() != 0) begin
          e  = mq.pop_front();
          g  = 1'b1;
          gr = e.r;
          gd = e.d;
        end else if (acc) begin
          g   = 1'b1;
          gr  = alu_reg;
          gd  = alu_data;
          acc = 1'b0;
        end
        if (acc) begin
          e.r = alu_reg;
          e.d = alu_data;
          mq.push_back(e);
        end
        m_we = g && (gr != 3'd0);
        if (m_we) begin
          m_waddr = gr;
          m_wdata = gd;
        end
      end
    end
  end

  // Directed stimulus with hand-computed expectations.
  initial begin : driver
    rst = 1'b0;
    idle();
    tick();
    // Reset state, and ALU must not be accepted while reset is held.
    set_in(1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 16'h1234);
    #1;
    chk_rf("reset", 1'b0, 3'd0, 16'h0000);
    chk("reset_count", 32'(fifo_count), 32'd0);
    chk("reset_pending", 32'(pending), 32'h00);
    chk("reset_ready", 32'(alu_ready), 32'd0);

    // Bypass on the first edge after release.
    rst = 1'b1;
    tick();
    chk_rf("bypass", 1'b1, 3'd3, 16'h1234);
    chk("bypass_count", 32'(fifo_count), 32'd0);
    idle();
    tick();
    chk_rf("hold", 1'b0, 3'd3, 16'h1234);

    // Same-register conflict: load first, ALU value last.
    set_in(1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd2, 16'h5555);
    #1;
    chk("conf_ready", 32'(alu_ready), 32'd1);
    tick();
    chk_rf("conf1", 1'b1, 3'd2, 16'hAAAA);
    chk("conf1_pending", 32'(pending), 32'h04);
    chk("conf1_count", 32'(fifo_count), 32'd1);
    idle();
    tick();
    chk_rf("conf2", 1'b1, 3'd2, 16'h5555);
    chk("conf2_pending", 32'(pending), 32'h00);
    tick();
    chk("conf3_we", 32'(rf_we), 32'd0);

    // Fill: loads for three cycles, ALU each cycle.
    set_in(1'b1, 3'd1, 16'h0101, 1'b1, 3'd4, 16'h0A01);
    tick();
    chk("full1_count", 32'(fifo_count), 32'd1);
    chk_rf("full1", 1'b1, 3'd1, 16'h0101);
    set_in(1'b1, 3'd5, 16'h0505, 1'b1, 3'd6, 16'h0A02);
    tick();
    chk("full2_count", 32'(fifo_count), 32'd2);
    chk("full2_pending", 32'(pending), 32'h50);
    set_in(1'b1, 3'd7, 16'h0707, 1'b1, 3'd3, 16'h0A03);
    #1;
    chk("full3_ready", 32'(alu_ready), 32'd0);
    tick();
    chk("full3_count", 32'(fifo_count), 32'd2);
    chk_rf("full3", 1'b1, 3'd7, 16'h0707);
    idle();
    #1;
    chk("drain_ready", 32'(alu_ready), 32'd1);
    tick();
    chk_rf("drain1", 1'b1, 3'd4, 16'h0A01);
    chk("drain1_count", 32'(fifo_count), 32'd1);
    tick();
    chk_rf("drain2", 1'b1, 3'd6, 16'h0A02);
    chk("drain2_count", 32'(fifo_count), 32'd0);
    tick();

    // Register 0 via bypass: accepted, no write, address/data held.
    set_in(1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 16'hFFFF);
    #1;
    chk("r0_ready", 32'(alu_ready), 32'd1);
    tick();
    chk_rf("r0", 1'b0, 3'd6, 16'h0A02);
    chk("r0_count", 32'(fifo_count), 32'd0);

    // Push and pop in the same cycle at count 1.
    set_in(1'b1, 3'd2, 16'h2222, 1'b1, 3'd5, 16'h5A5A);
    tick();
    chk("pp1_count", 32'(fifo_count), 32'd1);
    chk("pp1_pending", 32'(pending), 32'h20);
    set_in(1'b0, 3'd0, 16'h0, 1'b1, 3'd6, 16'h6B6B);
    #1;
    chk("pp2_ready", 32'(alu_ready), 32'd1);
    tick();
    chk("pp2_count", 32'(fifo_count), 32'd1);
    chk_rf("pp2", 1'b1, 3'd5, 16'h5A5A);
    chk("pp2_pending", 32'(pending), 32'h40);
    idle();
    tick();
    chk_rf("pp3", 1'b1, 3'd6, 16'h6B6B);
    chk("pp3_count", 32'(fifo_count), 32'd0);

    // Register 0 through the FIFO: pending while buffered, popped without a write.
    set_in(1'b1, 3'd1, 16'h0111, 1'b1, 3'd0, 16'h0F0F);
    tick();
    chk("fr0_pending", 32'(pending), 32'h01);
    idle();
    tick();
    chk_rf("fr0", 1'b0, 3'd1, 16'h0111);
    chk("fr0_count", 32'(fifo_count), 32'd0);

    // Reset mid-operation with two buffered entries.
    set_in(1'b1, 3'd1, 16'h1111, 1'b1, 3'd3, 16'h3333);
    tick();
    set_in(1'b1, 3'd2, 16'h2121, 1'b1, 3'd4, 16'h4444);
    tick();
    chk("mr_count", 32'(fifo_count), 32'd2);
    chk("mr_pending", 32'(pending), 32'h18);
    idle();
    rst = 1'b0;
    #1;
    chk("mr_rst_count", 32'(fifo_count), 32'd0);
    chk("mr_rst_pending", 32'(pending), 32'h00);
    chk_rf("mr_rst", 1'b0, 3'd0, 16'h0000);
    chk("mr_rst_ready", 32'(alu_ready), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("mr_after1_we", 32'(rf_we), 32'd0);
    chk("mr_after1_count", 32'(fifo_count), 32'd0);
    tick();
    chk("mr_after2_we", 32'(rf_we), 32'd0);

    // Mixed traffic checked by the model only.
    for (int i = 0; i < 24; i++) begin
      set_in((i % 3) == 0, 3'(i), 16'h1000 + 16'(i),
             (i % 4) != 3, 3'(i + 5), 16'h2000 + 16'(i));
      tick();
    end
    idle();
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
